// File: rtl/gfx_pkg.sv
// Shared graphics-pipeline constants and types: framebuffer geometry, RGB332 colour and the
// frame sequencer state encoding.
package gfx_pkg;

  localparam int unsigned FB_W     = 640;
  localparam int unsigned FB_H     = 480;
  localparam int unsigned FB_DEPTH = FB_W * FB_H;
  localparam int unsigned ADDR_W   = 19;

  typedef logic [7:0] rgb332_t;

  localparam rgb332_t BG_COLOR = 8'h00;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StXform,
    StRast,
    StWaitSwap
  } seq_state_e;

endpackage

// File: rtl/render_frame_sequencer_if.sv
// Handshake and clear-write bundle between the frame sequencer (master) and the
// xform / rast / framebuffer side (slave).
interface render_frame_sequencer_if
  import gfx_pkg::*;
#(
  parameter int unsigned IdxW  = 5,
  parameter int unsigned AddrW = 19
) ();

  logic            xform_req;
  logic [IdxW-1:0] xform_idx;
  logic            xform_ack;
  logic            rast_req;
  logic [IdxW-1:0] rast_idx;
  logic            rast_ack;
  logic            clear_we;
  logic [AddrW-1:0] clear_addr;
  rgb332_t         clear_data;

  modport master (
    output xform_req, xform_idx, rast_req, rast_idx, clear_we, clear_addr, clear_data,
    input  xform_ack, rast_ack
  );

  modport slave (
    input  xform_req, xform_idx, rast_req, rast_idx, clear_we, clear_addr, clear_data,
    output xform_ack, rast_ack
  );

endinterface

// File: rtl/fb_clear_counter.sv
// Back-buffer clear address generator: one write per cycle over 0..FB_DEPTH-1 after start;
// done flags the cycle carrying the last write.
module fb_clear_counter
  import gfx_pkg::*;
#(
  parameter int unsigned FB_DEPTH = gfx_pkg::FB_DEPTH,
  parameter int unsigned ADDR_W   = gfx_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FB_DEPTH - 1);

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign done = we_q && (addr_q == LastAddr);

  always_comb begin
    we_d   = we_q;
    addr_d = addr_q;
    if (start) begin
      we_d   = 1'b1;
      addr_d = '0;
    end else if (we_q) begin
      if (done) begin
        we_d   = 1'b0;
        addr_d = '0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
    end
  end

  assign we   = we_q;
  assign addr = addr_q;

endmodule

// File: rtl/render_frame_sequencer.sv
// Per-frame render scheduler: optional back-buffer clear, then xform/rast handshakes per
// triangle, buffer swap on vsync. Define RENDER_CLEAR_EN to build the clear phase.
module render_frame_sequencer
  import gfx_pkg::*;
#(
  parameter int unsigned MAX_TRIANGLES = 20,
  parameter int unsigned IDX_W         = 5,
  parameter int unsigned FB_DEPTH      = gfx_pkg::FB_DEPTH,
  parameter int unsigned ADDR_W        = gfx_pkg::ADDR_W,
  parameter rgb332_t     BG_COLOR      = gfx_pkg::BG_COLOR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vsync_start,
  input  logic [IDX_W-1:0]         tri_count,
  render_frame_sequencer_if.master bus,
  output logic                     buf_sel,
  output logic                     frame_done,
  output logic                     overrun,
  output logic                     busy
);

  localparam logic [IDX_W-1:0] MaxTri = IDX_W'(MAX_TRIANGLES);
  localparam logic [IDX_W-1:0] One    = IDX_W'(1);

  seq_state_e       state_q, state_d, start_st;
  logic [IDX_W-1:0] n_q, n_d, idx_q, idx_d, n_new;
  logic             xform_req_q, xform_req_d, rast_req_q, rast_req_d, busy_q, busy_d;
  logic             buf_sel_q, buf_sel_d, frame_done_q, frame_done_d, overrun_q, overrun_d;
  logic             clr_done;

  assign n_new = (tri_count > MaxTri) ? MaxTri : tri_count;

`ifdef RENDER_CLEAR_EN
  logic              clr_start, clr_we;
  logic [ADDR_W-1:0] clr_addr;

  assign start_st  = StClear;
  assign clr_start = (state_d == StClear) && (state_q != StClear);

  fb_clear_counter #(
    .FB_DEPTH(FB_DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_clear (
    .clk  (clk),
    .reset(reset),
    .start(clr_start),
    .we   (clr_we),
    .addr (clr_addr),
    .done (clr_done)
  );

  assign bus.clear_we   = clr_we;
  assign bus.clear_addr = clr_addr;
`else
  logic unused_cfg;

  assign start_st       = (n_new != '0) ? StXform : StWaitSwap;
  assign clr_done       = 1'b0;
  assign bus.clear_we   = 1'b0;
  assign bus.clear_addr = '0;
  assign unused_cfg     = ^{FB_DEPTH, ADDR_W};
`endif

  // Next state, triangle count and index.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle, StWaitSwap: begin
        if (vsync_start) begin
          n_d     = n_new;
          idx_d   = '0;
          state_d = start_st;
        end
      end
      StClear: begin
        if (clr_done) state_d = (n_q != '0) ? StXform : StWaitSwap;
      end
      StXform: begin
        if (bus.xform_ack) state_d = StRast;
      end
      StRast: begin
        if (bus.rast_ack) begin
          if (idx_q == n_q - One) begin
            state_d = StWaitSwap;
          end else begin
            idx_d   = idx_q + One;
            state_d = StXform;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs follow the next state; swap/overrun are vsync events on the current state.
  always_comb begin
    xform_req_d  = (state_d == StXform);
    rast_req_d   = (state_d == StRast);
    busy_d       = state_d inside {StClear, StXform, StRast};
    frame_done_d = vsync_start && (state_q == StWaitSwap);
    overrun_d    = vsync_start && (state_q inside {StClear, StXform, StRast});
    buf_sel_d    = buf_sel_q ^ frame_done_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      n_q          <= '0;
      idx_q        <= '0;
      xform_req_q  <= 1'b0;
      rast_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      buf_sel_q    <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      xform_req_q  <= xform_req_d;
      rast_req_q   <= rast_req_d;
      busy_q       <= busy_d;
      buf_sel_q    <= buf_sel_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.xform_req  = xform_req_q;
  assign bus.xform_idx  = idx_q;
  assign bus.rast_req   = rast_req_q;
  assign bus.rast_idx   = idx_q;
  assign bus.clear_data = BG_COLOR;
  assign buf_sel        = buf_sel_q;
  assign frame_done     = frame_done_q;
  assign overrun        = overrun_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_render_frame_sequencer.sv
// Self-checking bench for render_frame_sequencer: queue-of-jobs reference model compared every
// cycle, plus directed literal checks; random acks, spurious acks and vsync spacing.
module tb_render_frame_sequencer;

  localparam int unsigned MaxTri  = 20;
  localparam int unsigned IdxW    = 5;
  localparam int unsigned FbDepth = 16;
  localparam int unsigned AddrW   = 19;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            vsync_start = 1'b0;
  logic [IdxW-1:0] tri_count = '0;
  logic            buf_sel, frame_done, overrun, busy;

  render_frame_sequencer_if #(.IdxW(IdxW), .AddrW(AddrW)) bus ();

  render_frame_sequencer #(
    .MAX_TRIANGLES(MaxTri),
    .IDX_W        (IdxW),
    .FB_DEPTH     (FbDepth),
    .ADDR_W       (AddrW),
    .BG_COLOR     (8'h00)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vsync_start(vsync_start),
    .tri_count  (tri_count),
    .bus        (bus.master),
    .buf_sel    (buf_sel),
    .frame_done (frame_done),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fail_prints = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (fail_prints < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      fail_prints++;
    end
  endtask

  // Reference model: a frame is a queue of pending jobs (clear writes, xform, rast).
  typedef struct {
    int kind;  // 0 clear write, 1 xform, 2 rast
    int idx;   // triangle index or clear address
  } job_t;

  job_t jobs[$];
  bit   m_active, m_buf_sel, m_frame_done, m_overrun, m_rendering, m_start;
  int   m_n;
  bit   cmp_en = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      jobs.delete();
      m_active = 0; m_buf_sel = 0; m_frame_done = 0; m_overrun = 0;
    end else begin
      m_rendering  = jobs.size() > 0;
      m_start      = vsync_start && (!m_active || !m_rendering);
      m_frame_done = vsync_start && m_active && !m_rendering;
      m_overrun    = vsync_start && m_rendering;
      if (m_frame_done) m_buf_sel = !m_buf_sel;
      if (m_rendering) begin
        if (jobs[0].kind == 0) void'(jobs.pop_front());
        else if (jobs[0].kind == 1 && bus.xform_ack) void'(jobs.pop_front());
        else if (jobs[0].kind == 2 && bus.rast_ack) void'(jobs.pop_front());
      end
      if (m_start) begin
        m_active = 1;
        m_n = (int'(tri_count) > MaxTri) ? MaxTri : int'(tri_count);
`ifdef RENDER_CLEAR_EN
        for (int a = 0; a < FbDepth; a++) jobs.push_back('{kind: 0, idx: a});
`endif
        for (int i = 0; i < m_n; i++) begin
          jobs.push_back('{kind: 1, idx: i});
          jobs.push_back('{kind: 2, idx: i});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      bit ex_busy, ex_x, ex_r, ex_we;
      ex_busy = jobs.size() > 0;
      ex_x    = ex_busy && jobs[0].kind == 1;
      ex_r    = ex_busy && jobs[0].kind == 2;
      ex_we   = ex_busy && jobs[0].kind == 0;
      check("busy", busy, ex_busy);
      check("xform_req", bus.xform_req, ex_x);
      check("rast_req", bus.rast_req, ex_r);
      check("clear_we", bus.clear_we, ex_we);
      if (ex_x) check("xform_idx", bus.xform_idx, jobs[0].idx);
      if (ex_r) check("rast_idx", bus.rast_idx, jobs[0].idx);
      if (ex_we) check("clear_addr", bus.clear_addr, jobs[0].idx);
      check("clear_data", bus.clear_data, 0);
      check("frame_done", frame_done, m_frame_done);
      check("overrun", overrun, m_overrun);
      check("buf_sel", buf_sel, m_buf_sel);
    end
  end

  // Ack responders: random latency, optional rast hold-off, occasional stray acks.
  bit rast_hold = 1'b0;
  int xf_age = 0, xf_dly = 2, rs_age = 0, rs_dly = 2;

  initial begin
    bus.xform_ack = 1'b0;
    bus.rast_ack  = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.xform_ack = 1'b0;
      bus.rast_ack  = 1'b0;
      if (reset) continue;
      if (bus.xform_req) begin
        if (xf_age >= xf_dly) begin
          bus.xform_ack = 1'b1; xf_age = 0; xf_dly = $urandom_range(0, 3);
        end else xf_age++;
      end else if ($urandom_range(0, 15) == 0) bus.xform_ack = 1'b1;
      if (bus.rast_req) begin
        if (!rast_hold && rs_age >= rs_dly) begin
          bus.rast_ack = 1'b1; rs_age = 0; rs_dly = $urandom_range(0, 3);
        end else rs_age++;
      end else if ($urandom_range(0, 15) == 0) bus.rast_ack = 1'b1;
    end
  end

  int pair_cnt = 0;
  int last_rast_idx = -1;

  always @(negedge clk) begin
    if (!reset && bus.rast_req && bus.rast_ack) begin
      pair_cnt++;
      last_rast_idx = int'(bus.rast_idx);
    end
  end

  task automatic pulse_vsync();
    vsync_start = 1'b1;
    @(posedge clk); #1;
    vsync_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 3000 && busy; k++) begin
      @(posedge clk); #1;
    end
    check(name, busy, 0);
  endtask

  task automatic wait_rast(input int idx, input string name);
    int k;
    for (k = 0; k < 3000 && !(bus.rast_req && int'(bus.rast_idx) == idx); k++) begin
      @(posedge clk); #1;
    end
    check(name, bus.rast_req && int'(bus.rast_idx) == idx, 1);
  endtask

  task automatic check_start(input string name);
`ifdef RENDER_CLEAR_EN
    check({name, "_we"}, bus.clear_we, 1);
    check({name, "_addr"}, bus.clear_addr, 0);
    check({name, "_xreq"}, bus.xform_req, 0);
`else
    check({name, "_xreq"}, bus.xform_req, 1);
    check({name, "_xidx"}, bus.xform_idx, 0);
    check({name, "_we"}, bus.clear_we, 0);
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_xreq", bus.xform_req, 0);
    check("rst_rreq", bus.rast_req, 0);
    check("rst_we", bus.clear_we, 0);
    check("rst_addr", bus.clear_addr, 0);
    check("rst_bufsel", buf_sel, 0);
    check("rst_fdone", frame_done, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // Three triangles from idle.
    tri_count = 3; pair_cnt = 0;
    pulse_vsync();
    check_start("t1");
    wait_idle("t1_idle");
    check("t1_pairs", pair_cnt, 3);
    tri_count = 0;
    pulse_vsync();
    check("t1_swap_bufsel", buf_sel, 1);
    check("t1_swap_fdone", frame_done, 1);

    // Empty triangle list.
    pair_cnt = 0;
    wait_idle("t2_idle");
    check("t2_pairs", pair_cnt, 0);
    check("t2_xreq", bus.xform_req, 0);
    tri_count = 2;
    pulse_vsync();
    check("t2_swap_bufsel", buf_sel, 0);

    // Overrun: rast held across a vsync.
    rast_hold = 1'b1;
    wait_rast(0, "t3_rast_seen");
    pulse_vsync();
    check("t3_overrun", overrun, 1);
    check("t3_no_swap", frame_done, 0);
    check("t3_bufsel", buf_sel, 0);
    rast_hold = 1'b0;
    wait_idle("t3_idle");
    tri_count = 31;
    pulse_vsync();
    check("t3_swap_fdone", frame_done, 1);
    check("t3_swap_bufsel", buf_sel, 1);

    // Clamped list.
    pair_cnt = 0;
    wait_idle("t4_idle");
    check("t4_pairs", pair_cnt, 20);
    check("t4_last_idx", last_rast_idx, 19);
    tri_count = 10;
    pulse_vsync();

    // Reset in the middle of RAST at idx 4.
    wait_rast(4, "t5_rast4");
    reset = 1'b1;
    #1;
    check("t5_rreq", bus.rast_req, 0);
    check("t5_ridx", bus.rast_idx, 0);
    check("t5_busy", busy, 0);
    check("t5_bufsel", buf_sel, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    tri_count = 5;
    pulse_vsync();
    check_start("t5_restart");
    check("t5_no_swap", frame_done, 0);

    // Random frames with random vsync spacing.
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(3, 180)) @(posedge clk);
      #1;
      tri_count = IdxW'($urandom_range(0, 31));
      pulse_vsync();
    end
    wait_idle("final_idle");
    pulse_vsync();
    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
